// File: rtl/if_arb_pkg.sv
// Shared types and helpers for the request-array arbiter.
// State encoding and index-width sizing used across the arbiter files.
package if_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/if_array_arbiter_rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping.
// Purely combinational; any flags a non-empty request vector.
module rr_pick
    import if_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Walk offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/if_array_arbiter.sv
// Burst-capped round-robin arbiter from N requesters to one
// registered output beat with valid/ready backpressure.
module if_array_arbiter
    import if_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_src,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int IW = idx_w(N);
    localparam int CW = idx_w(BURST);

    arb_state_t    state;
    logic [IW-1:0] g;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick;
    logic          any;
    logic [CW-1:0] cnt;

    logic [W-1:0]  sel_data;
    logic          sel_valid;
    logic          sel_last;
    logic          room;
    logic          xfer;
    logic          grant_end;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (ptr),
        .idx (pick),
        .any (any)
    );

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (g == IW'(i)) begin
                sel_data  = req_data[i*W +: W];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

    // Output register can take a beat when empty or draining this cycle.
    assign room      = !out_valid || out_ready;
    assign xfer      = (state == OWN) && sel_valid && room;
    assign grant_end = sel_last || (cnt == CW'(BURST - 1));
    assign busy      = (state == OWN);

    always_comb begin
        req_ready = '0;
        if (state == OWN) begin
            req_ready[g] = room;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (any) begin
                        g     <= pick;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (xfer) begin
                        if (grant_end) begin
                            state <= IDLE;
                            ptr   <= (g == IW'(N - 1)) ? '0 : g + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_array_arbiter.sv
// Directed scoreboard bench for if_array_arbiter.
// Per-requester beat queues feed the DUT; expected beats are compared on output.
module tb_if_array_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int BURST = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready;
    logic           busy;

    always #5 clk = ~clk;

    if_array_arbiter #(
        .N     (N),
        .W     (W),
        .BURST (BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int t0;
    logic ordy;

    logic [8:0] sq [N][$];
    int exp_q[$];
    int fire_t[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int i, input logic [7:0] d, input logic l);
        sq[i].push_back({l, d});
    endtask

    task automatic expect_beat(input int s, input int d);
        exp_q.push_back(s * 256 + d);
    endtask

    // One clock: drive heads of queues, sample before the edge, pop on handshake.
    task automatic cyc();
        logic [N-1:0] hs;
        logic         fire;
        logic [31:0]  obs;
        for (int i = 0; i < N; i++) begin
            if (sq[i].size() > 0) begin
                req_valid[i]        = 1'b1;
                req_last[i]         = sq[i][0][8];
                req_data[i*W +: W]  = sq[i][0][7:0];
            end else begin
                req_valid[i]        = 1'b0;
                req_last[i]         = 1'b0;
                req_data[i*W +: W]  = '0;
            end
        end
        out_ready = ordy;
        #1;
        hs   = req_valid & req_ready;
        fire = out_valid && out_ready;
        obs  = 32'({out_src, out_data});
        chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
        @(posedge clk);
        cyc_n++;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) void'(sq[i].pop_front());
        end
        if (fire) begin
            fire_t.push_back(cyc_n - 1);
            chk("beat_expected", 32'(exp_q.size()), 32'(exp_q.size() > 0 ? exp_q.size() : 1));
            if (exp_q.size() > 0) chk("beat_src_data", obs, exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int bound);
        int k = 0;
        while (exp_q.size() > 0 && k < bound) begin
            cyc();
            k++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_out_data"}, 32'(out_data), 0);
        chk({tag, "_out_src"}, 32'(out_src), 0);
    endtask

    initial begin
        int gaps[$];
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        ordy      = 1'b1;
        rst_n     = 1'b0;

        // Reset held with every requester offering a beat.
        for (int i = 0; i < N; i++) add(i, 8'hEE, 1'b1);
        #1;
        chk_reset_outs("rst_init");
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk_reset_outs("rst_hold");
        end
        for (int i = 0; i < N; i++) sq[i].delete();
        rst_n = 1'b1;

        // Round robin, single-beat grants.
        for (int i = 0; i < N; i++) add(i, 8'(i * 16), 1'b1);
        add(0, 8'h01, 1'b1);
        expect_beat(0, 8'h00);
        expect_beat(1, 8'h10);
        expect_beat(2, 8'h20);
        expect_beat(3, 8'h30);
        expect_beat(0, 8'h01);
        t0 = cyc_n;
        fire_t.delete();
        drain("rr", 40);
        chk("rr_fire_count", 32'(fire_t.size()), 5);
        if (fire_t.size() == 5) begin
            chk("rr_first_latency", 32'(fire_t[0] - t0), 2);
            for (int k = 1; k < 5; k++)
                chk("rr_gap", 32'(fire_t[k] - fire_t[k-1]), 2);
        end

        // Burst cap splits an 8-beat stream into two grants.
        for (int d = 8'h10; d <= 8'h17; d++) begin
            add(2, 8'(d), 1'b0);
            expect_beat(2, d);
        end
        fire_t.delete();
        drain("burst", 60);
        chk("burst_fire_count", 32'(fire_t.size()), 8);
        gaps = '{1, 1, 1, 2, 1, 1, 1};
        if (fire_t.size() == 8) begin
            for (int k = 1; k < 8; k++)
                chk("burst_gap", 32'(fire_t[k] - fire_t[k-1]), 32'(gaps[k-1]));
        end

        // Backpressure holds the registered beat.
        ordy = 1'b0;
        add(1, 8'hA5, 1'b0);
        add(1, 8'hA6, 1'b1);
        expect_beat(1, 8'hA5);
        expect_beat(1, 8'hA6);
        cyc();
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_data", 32'(out_data), 32'h A5);
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_busy", 32'(busy), 1);
            cyc();
        end
        ordy = 1'b1;
        drain("bp", 20);

        // Move ptr to 3, then wrap and skip over idle requesters.
        add(2, 8'h55, 1'b1);
        expect_beat(2, 8'h55);
        drain("wrap_prep", 20);
        add(0, 8'h60, 1'b1);
        add(0, 8'h61, 1'b1);
        add(2, 8'h62, 1'b1);
        expect_beat(0, 8'h60);
        expect_beat(2, 8'h62);
        expect_beat(0, 8'h61);
        drain("wrap", 40);

        // Reset in the middle of a 4-beat grant drops the held beat.
        add(3, 8'hB0, 1'b0);
        add(3, 8'hB1, 1'b0);
        add(3, 8'hB2, 1'b0);
        add(3, 8'hB3, 1'b1);
        expect_beat(3, 8'hB0);
        drain("mid_pre", 20);
        chk("mid_held_valid", 32'(out_valid), 1);
        chk("mid_held_data", 32'(out_data), 32'h B1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("mid_rst");
        cyc();
        cyc();
        chk_reset_outs("mid_rst_hold");
        rst_n = 1'b1;
        add(1, 8'hC0, 1'b1);
        expect_beat(1, 8'hC0);
        expect_beat(3, 8'hB2);
        expect_beat(3, 8'hB3);
        drain("mid_post", 40);
        for (int k = 0; k < 3; k++) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
